// File: rtl/pow_pipe_pkg.sv
`default_nettype none
// ============================================================================
// Module   : pow_pipe_pkg
// Brief    : Shared helpers for the pow_n_pipe_flow pipeline: exponent
//            saturation and stage-record field widths.
// Revision : 1.0 - initial release
// ============================================================================
package pow_pipe_pkg;

    // Width of the raw acc*base product; its upper half flags overflow.
    function automatic int unsigned prod_w(input int unsigned w);
        return 2 * w;
    endfunction

    // Width of the occupancy counter for a given exponent field width.
    function automatic int unsigned occ_w(input int unsigned ew);
        return ew + 1;
    endfunction

    function automatic int unsigned sat_exp(input int unsigned e, input int unsigned n);
        return (e > n) ? n : e;
    endfunction

endpackage
`default_nettype wire

// File: rtl/pow_pipe_stage.sv
`default_nettype none
// ============================================================================
// Module   : pow_pipe_stage
// Brief    : One register stage Si (i>=1): multiplies the accumulator by the
//            base while the remaining exponent exceeds the stage index.
// Revision : 1.0 - initial release
// ============================================================================
module pow_pipe_stage
    import pow_pipe_pkg::*;
#(
    parameter int W  = 8,
    parameter int EW = 3,
    parameter int I  = 1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          ld,
    input  logic          in_vld,
    input  logic [W-1:0]  in_base,
    input  logic [EW-1:0] in_exp,
    input  logic [W-1:0]  in_acc,
    input  logic          in_ovf,
    output logic          out_vld,
    output logic [W-1:0]  out_base,
    output logic [EW-1:0] out_exp,
    output logic [W-1:0]  out_acc,
    output logic          out_ovf
);

    localparam int PW = int'(prod_w(W));

    logic [PW-1:0] w_prod;
    logic          vld_d,  vld_q;
    logic [W-1:0]  base_d, base_q;
    logic [EW-1:0] exp_d,  exp_q;
    logic [W-1:0]  acc_d,  acc_q;
    logic          ovf_d,  ovf_q;

    always_comb begin
        w_prod = PW'(in_acc) * PW'(in_base);
        vld_d  = vld_q;
        base_d = base_q;
        exp_d  = exp_q;
        acc_d  = acc_q;
        ovf_d  = ovf_q;
        if (ld) begin
            vld_d  = in_vld;
            base_d = in_base;
            exp_d  = in_exp;
            if (in_exp > EW'(I)) begin
                acc_d = w_prod[W-1:0];
                ovf_d = in_ovf | (|w_prod[PW-1:W]);
            end else begin
                acc_d = in_acc;
                ovf_d = in_ovf;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_q <= 1'b0;
        end else begin
            vld_q <= vld_d;
        end
    end

    // Payload is meaningless while vld is clear, so it carries no reset.
    always_ff @(posedge clk) begin
        base_q <= base_d;
        exp_q  <= exp_d;
        acc_q  <= acc_d;
        ovf_q  <= ovf_d;
    end

    assign out_vld  = vld_q;
    assign out_base = base_q;
    assign out_exp  = exp_q;
    assign out_acc  = acc_q;
    assign out_ovf  = ovf_q;

endmodule
`default_nettype wire

// File: rtl/pow_n_pipe_flow.sv
`default_nettype none
// ============================================================================
// Module   : pow_n_pipe_flow
// Brief    : N-stage bubble-collapsing pipeline computing arg**min(exp,N)
//            modulo 2**W with overflow flag and valid/ready flow control.
// Revision : 1.0 - initial release
// ============================================================================
module pow_n_pipe_flow
    import pow_pipe_pkg::*;
#(
    parameter int W  = 8,
    parameter int N  = 5,
    parameter int EW = 3
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          clk_en,
    input  logic          arg_vld,
    output logic          arg_rdy,
    input  logic [W-1:0]  arg,
    input  logic [EW-1:0] exp,
    output logic          res_vld,
    input  logic          res_rdy,
    output logic [W-1:0]  res,
    output logic          res_ovf,
    output logic [EW:0]   occ
);

    localparam int OW = int'(occ_w(EW));

    logic [N-1:0]  vld;
    logic [N-1:0]  ovf;
    logic [W-1:0]  base [N];
    logic [W-1:0]  acc  [N];
    logic [EW-1:0] xp   [N];

    logic [N-1:0]  w_can;
    logic [N-1:0]  w_ld;
    logic [EW-1:0] w_exp_sat;
    logic [OW-1:0] w_occ;
    logic          w_unused_tail;

    // A stage may load if it is empty or its content leaves this edge; any
    // bubble downstream therefore lets everything behind it close up.
    always_comb begin : p_can
        logic c;
        c = !vld[N-1] || res_rdy;
        w_can = '0;
        w_can[N-1] = c;
        for (int j = N - 2; j >= 0; j--) begin
            c = !vld[j] || c;
            w_can[j] = c;
        end
    end

    assign w_ld    = {N{clk_en}} & w_can;
    assign arg_rdy = w_can[0];

    logic          s0_vld_d,  s0_vld_q;
    logic [W-1:0]  s0_base_d, s0_base_q;
    logic [EW-1:0] s0_exp_d,  s0_exp_q;
    logic [W-1:0]  s0_acc_d,  s0_acc_q;

    always_comb begin
        w_exp_sat = EW'(sat_exp(32'(exp), N));
        s0_vld_d  = s0_vld_q;
        s0_base_d = s0_base_q;
        s0_exp_d  = s0_exp_q;
        s0_acc_d  = s0_acc_q;
        if (w_ld[0]) begin
            s0_vld_d  = arg_vld;
            s0_base_d = arg;
            s0_exp_d  = w_exp_sat;
            s0_acc_d  = (w_exp_sat == '0) ? W'(1) : arg;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s0_vld_q <= 1'b0;
        end else begin
            s0_vld_q <= s0_vld_d;
        end
    end

    always_ff @(posedge clk) begin
        s0_base_q <= s0_base_d;
        s0_exp_q  <= s0_exp_d;
        s0_acc_q  <= s0_acc_d;
    end

    assign vld[0]  = s0_vld_q;
    assign base[0] = s0_base_q;
    assign xp[0]   = s0_exp_q;
    assign acc[0]  = s0_acc_q;
    assign ovf[0]  = 1'b0;

    for (genvar i = 1; i < N; i++) begin : g_stage
        pow_pipe_stage #(
            .W  (W),
            .EW (EW),
            .I  (i)
        ) u_stage (
            .clk      (clk),
            .rst_n    (rst_n),
            .ld       (w_ld[i]),
            .in_vld   (vld[i-1]),
            .in_base  (base[i-1]),
            .in_exp   (xp[i-1]),
            .in_acc   (acc[i-1]),
            .in_ovf   (ovf[i-1]),
            .out_vld  (vld[i]),
            .out_base (base[i]),
            .out_exp  (xp[i]),
            .out_acc  (acc[i]),
            .out_ovf  (ovf[i])
        );
    end

    always_comb begin
        w_occ = '0;
        for (int j = 0; j < N; j++) begin
            w_occ = w_occ + OW'(vld[j]);
        end
    end

    assign occ     = w_occ;
    assign res_vld = vld[N-1];
    assign res     = acc[N-1];
    assign res_ovf = ovf[N-1];

    // Base and exponent are not needed once a record reaches the tail.
    assign w_unused_tail = ^{base[N-1], xp[N-1]};

endmodule
`default_nettype wire

// File: tb/tb_pow_n_pipe_flow.sv
`default_nettype none
// ============================================================================
// Module   : tb_pow_n_pipe_flow
// Brief    : Self-checking bench for pow_n_pipe_flow (W=8, N=5).
// Revision : 1.0 - initial release
// ============================================================================
module tb_pow_n_pipe_flow;

    localparam int W  = 8;
    localparam int N  = 5;
    localparam int EW = 3;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          clk_en = 1'b0;
    logic          arg_vld = 1'b0;
    logic [W-1:0]  arg = '0;
    logic [EW-1:0] exp = '0;
    logic          res_rdy = 1'b0;
    logic          arg_rdy;
    logic          res_vld;
    logic [W-1:0]  res;
    logic          res_ovf;
    logic [EW:0]   occ;

    int checks = 0;
    int failures = 0;

    logic [W:0] sb [$];
    int         mocc = 0;
    bit         last_acc;
    bit         last_cons;

    pow_n_pipe_flow #(.W(W), .N(N), .EW(EW)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .clk_en  (clk_en),
        .arg_vld (arg_vld),
        .arg_rdy (arg_rdy),
        .arg     (arg),
        .exp     (exp),
        .res_vld (res_vld),
        .res_rdy (res_rdy),
        .res     (res),
        .res_ovf (res_ovf),
        .occ     (occ)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout required=finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        checks++;
        assert (obs === expv) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
        end
    endtask

    // {ovf, value} of a**min(e,N) using exact integer arithmetic.
    function automatic logic [W:0] ref_pow(input int a, input int e);
        longint p;
        int es;
        p  = 1;
        es = (e > N) ? N : e;
        for (int k = 0; k < es; k++) p = p * a;
        return {(p >= (longint'(1) << W)), p[W-1:0]};
    endfunction

    // One clock cycle: drive, check pre-edge behaviour, clock, check post-edge.
    task automatic cycle(input bit ce, input bit av, input logic [W-1:0] a,
                         input logic [EW-1:0] e, input bit rr);
        logic          pre_vld;
        logic [W:0]    pre_out;
        logic [W:0]    front;
        clk_en  = ce;
        arg_vld = av;
        arg     = a;
        exp     = e;
        res_rdy = rr;
        #1;
        chk("arg_rdy", arg_rdy, ((mocc < N) || rr) ? 1 : 0);
        last_acc  = ce && av && arg_rdy;
        last_cons = ce && res_vld && rr;
        pre_vld   = res_vld;
        pre_out   = {res_ovf, res};
        if (res_vld) begin
            if (sb.size() == 0) begin
                chk("res_unexpected", 1, 0);
            end else begin
                front = sb[0];
                chk("res", res, front[W-1:0]);
                chk("res_ovf", res_ovf, front[W]);
            end
        end
        @(posedge clk);
        #1;
        if (last_cons && sb.size() != 0) void'(sb.pop_front());
        if (last_acc) sb.push_back(ref_pow(int'(a), int'(e)));
        mocc = mocc + (last_acc ? 1 : 0) - (last_cons ? 1 : 0);
        chk("occ", occ, mocc);
        if (!ce) begin
            chk("freeze_vld", res_vld, pre_vld);
            if (pre_vld) chk("freeze_res", {res_ovf, res}, pre_out);
        end
    endtask

    task automatic directed(input string tag, input int a, input int e, input int xres, input int xovf);
        int n_edges;
        cycle(1, 1, W'(a), EW'(e), 1);
        chk({tag, "_acc"}, last_acc, 1);
        n_edges = 1;
        while (!res_vld && n_edges < 20) begin
            cycle(1, 0, '0, '0, 1);
            n_edges++;
        end
        chk({tag, "_lat"}, n_edges, N);
        chk({tag, "_res"}, res, xres);
        chk({tag, "_ovf"}, res_ovf, xovf);
        cycle(1, 0, '0, '0, 1);
        chk({tag, "_taken"}, last_cons, 1);
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1;
        chk("rst_res_vld", res_vld, 0);
        chk("rst_occ", occ, 0);
        chk("rst_arg_rdy", arg_rdy, 1);
        rst_n = 1'b1;

        directed("p3e5", 3, 5, 243, 0);
        directed("p4e5", 4, 5, 0, 1);
        directed("p2e7", 2, 7, 32, 0);
        directed("p7e0", 7, 0, 1, 0);
        directed("p200e1", 200, 1, 200, 0);

        // Back-to-back fill with the consumer stalled, then a full-rate drain.
        begin
            int acc_n;
            acc_n = 0;
            for (int k = 0; k < 10 && acc_n < N; k++) begin
                cycle(1, 1, W'(k + 2), EW'(2), 0);
                if (last_acc) acc_n++;
            end
            chk("fill_accepts", acc_n, N);
            chk("fill_occ", occ, N);
            chk("fill_arg_rdy", arg_rdy, 0);
            for (int k = 0; k < 8; k++) begin
                cycle(1, (k < 3), W'(k + 7), EW'(3), 1);
                chk($sformatf("drain_%0d", k), last_cons, 1);
                if (k < 3) chk($sformatf("swap_acc_%0d", k), last_acc, 1);
                if (k < 3) chk($sformatf("swap_occ_%0d", k), occ, N);
            end
            chk("drain_occ", occ, 0);
        end

        // Random enable, valid and ready.
        for (int k = 0; k < 300; k++) begin
            cycle(bit'($urandom_range(0, 1)), bit'($urandom_range(0, 1)),
                  W'($urandom), EW'($urandom_range(0, 7)), bit'($urandom_range(0, 1)));
        end
        for (int k = 0; k < 40 && sb.size() != 0; k++) begin
            cycle(1, 0, '0, '0, 1);
        end
        chk("rand_drained", sb.size(), 0);

        // Asynchronous reset with three requests in flight.
        for (int k = 0; k < 3; k++) cycle(1, 1, W'(k + 3), EW'(4), 0);
        for (int k = 0; k < 4; k++) cycle(1, 0, '0, '0, 0);
        chk("pre_rst_occ", occ, 3);
        chk("pre_rst_vld", res_vld, 1);
        #1;
        rst_n = 1'b0;
        #1;
        chk("arst_res_vld", res_vld, 0);
        chk("arst_occ", occ, 0);
        chk("arst_arg_rdy", arg_rdy, 1);
        sb.delete();
        mocc = 0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        directed("post_rst", 3, 5, 243, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
